// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution unit: FSM encoding, instruction size, fetch record.
// Record fields are REC_XLEN wide and must match the XLEN the top is built with.
package branch_resolve_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int INSTR_BYTES = 4;
  localparam int REC_XLEN    = 32;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [REC_XLEN-1:0] pred_pc;
    logic                is_branch;
  } rec_t;

endpackage

// File: rtl/branch_resolve_fifo.sv
// resolve_fifo: in-order queue of fetch records; push/pop take effect on the next edge.
// Push when full is dropped unless a pop happens the same cycle; clear wins over push/pop.
module resolve_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rec_t          push_dat,
  input  logic          pop,
  input  logic          clear,
  output rec_t          head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rec_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign rd_ok    = pop && !empty;
  assign wr_ok    = push && (!full || rd_ok) && !clear;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers are exactly log2(DEPTH) bits, so increment wraps for free.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: compares resolved next PC against IF's prediction, trains predictor, flushes.
// Feedback/flush registered (cycle after resolve); push dropped when full, on mispredict, in FLUSH.
// Optional BRANCH_RESOLVE_STATS_EN adds stat_branches / stat_mispredicts counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  XLEN  = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_pred_pc,
  input  logic            push_is_branch,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  output logic            branch,
  output logic            branch_taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_t          state;
  state_t          state_nxt;
  rec_t            push_rec;
  rec_t            head;
  logic            pop;
  logic            clear;
  logic            push_en;
  logic            mispredict;
  logic [XLEN-1:0] actual_npc;

  assign push_rec = '{pc: push_pc, pred_pc: push_pred_pc, is_branch: push_is_branch};

  resolve_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_en),
    .push_dat (push_rec),
    .pop      (pop),
    .clear    (clear),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Non-branch records still mispredict if IF guessed anything but the fall-through PC.
  assign actual_npc = (resolve_taken && head.is_branch) ? resolve_target
                                                        : head.pc + XLEN'(INSTR_BYTES);
  assign mispredict = (actual_npc != head.pred_pc);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clear     = 1'b0;
    push_en   = 1'b0;
    case (state)
      ST_RUN: begin
        pop     = resolve_valid && !empty;
        clear   = pop && mispredict;
        push_en = push && !clear;
        if (clear) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      branch       <= 1'b0;
      branch_taken <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      state        <= state_nxt;
      branch       <= pop && head.is_branch;
      branch_taken <= pop && head.is_branch && resolve_taken;
      if (clear) redirect_pc <= actual_npc;
    end
  end

  assign flush = (state == ST_FLUSH);

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && head.is_branch) stat_branches <= stat_branches + 32'd1;
      if (clear)                 stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-side branch resolution unit for the pipeline. It receives every IF-issued fetch record (PC, predicted next PC, branch flag) in a small in-order queue. When execute resolves the oldest record, the unit compares the actual next PC against the prediction. It drives the `branch`/`branch_taken` training feedback back into IF's predictor and issues a one-cycle flush with a redirect PC on a mispredict.

## Interface
Parameters:
- DEPTH, 4, in-flight record queue depth; power of two, ≥2
- XLEN, 32, address width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  IF issues one record this cycle
- push_pc  in  XLEN  PC of issued instruction
- push_pred_pc  in  XLEN  predicted next PC from IF
- push_is_branch  in  1  issued instruction is a conditional branch
- full  out  1  queue holds DEPTH records
- empty  out  1  queue holds 0 records
- count  out  $clog2(DEPTH+1)  occupancy
- resolve_valid  in  1  execute resolves oldest record this cycle
- resolve_taken  in  1  actual branch direction (ignored for non-branch)
- resolve_target  in  XLEN  actual taken target
- branch  out  1  predictor update strobe (one cycle)
- branch_taken  out  1  outcome paired with `branch`
- flush  out  1  mispredict; squash younger work
- redirect_pc  out  XLEN  correct fetch PC, valid while `flush`=1

## Operation
- Queue: circular buffer, rd/wr pointers of $clog2(DEPTH) bits that wrap naturally, plus a separate count.
- Actual next PC: resolve_taken && is_branch ? resolve_target : pc + 4, computed modulo 2^XLEN.
- Mispredict: actual next PC ≠ stored pred_pc; applies to non-branch records too.
- FSM states:
  - RUN: normal operation.
  - FLUSH: one cycle.
- RUN → FLUSH on a mispredicting resolve. FLUSH → RUN unconditionally.
- On a resolve in RUN:
  - Pop the head record.
  - If is_branch, pulse `branch` and set `branch_taken`=resolve_taken.
- On mispredict, additionally:
  - Clear the queue: pointers and count go to 0.
  - Latch redirect_pc = actual next PC.
  - Enter FLUSH.
- Push is dropped in these cases:
  - when full and no same-cycle pop;
  - in a mispredicting resolve cycle;
  - in any cycle with state=FLUSH.
- resolve_valid while empty or in FLUSH: ignored; no outputs change.
- Push and pop in the same cycle when full: both succeed; count unchanged.

## Timing
- Reset values:
  - state=RUN, count=0, empty=1, full=0;
  - branch=0, branch_taken=0, flush=0, redirect_pc=0;
  - statistics counters=0.
- branch, branch_taken, flush, redirect_pc are registered: asserted cycle N+1 for a resolve in cycle N, high exactly one cycle.
- full, empty, count reflect registered state (no combinational path from push/resolve).
- Push accepted in cycle N is visible in count in cycle N+1 and resolvable from N+1.
- rst during FLUSH or with queued records: all state returns to reset values next edge; flush not asserted afterwards.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: adds outputs `stat_branches` (32 bits, +1 per resolved branch record) and `stat_mispredicts` (32 bits, +1 per mispredict). Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package: FSM state encoding (ST_RUN, ST_FLUSH), INSTR_BYTES=4 constant, record struct {pc, pred_pc, is_branch}.
- One sub-module: `resolve_fifo` (DEPTH-entry record queue, push/pop/clear, full/empty/count). The top level holds the compare, FSM, feedback registers and stats.

## Test plan
- Correct prediction: push {pc=0x100, pred=0x104, br=0}, resolve → no flush, branch=0, count 1→0.
- Taken branch predicted: push {0x200, 0x180, br=1}, resolve taken target 0x180 → branch=1, branch_taken=1, flush=0, one cycle later.
- Mispredict flush: push 3 records with head {0x300, 0x304, br=1}, resolve taken target 0x400 → next cycle flush=1, redirect_pc=0x400, count=0. A push presented in the FLUSH cycle is dropped.
- Full/wrap: DEPTH=4.
  - Push 4 → full=1; 5th push ignored.
  - Then push+resolve together 6 cycles → full stays 1, records pop in order across the pointer wrap.
- Resolve when empty → no branch/flush pulse, count stays 0.
- rst asserted in the FLUSH cycle with queue content → next cycle all outputs at reset values; with BRANCH_RESOLVE_STATS_EN defined, stat_mispredicts=0.
